// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encoding and the iteration count.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int ITER_CNT = 32;

endpackage

// File: rtl/muldiv_divider.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder, subtract the divisor, keep it if non-negative.
module muldiv_divider #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // rem < divisor always holds, so a non-negative diff fits in XLEN bits
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (diff[XLEN]) begin
      rem_next = rem_sh[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (32-cycle shift-add / restoring divide).
// Define MULDIV_DIV_EN to include the divider; otherwise divide ops return 0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q;
  logic [4:0]        cnt_q;
  logic [2:0]        f3_q;
  logic              neg_a_q;
  logic              neg_b_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   result_q;

  logic              sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   calc_res;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Operand decode: signedness, magnitudes and the cases that skip iteration
  always_comb begin
    sgn_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
            (funct3 == F3_DIV)  || (funct3 == F3_REM);
    sgn_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    neg_a = sgn_a & op_a[XLEN-1];
    neg_b = sgn_b & op_b[XLEN-1];
    abs_a = cneg(op_a, neg_a);
    abs_b = cneg(op_b, neg_b);
    special     = 1'b0;
    special_res = '0;
`ifdef MULDIV_DIV_EN
    if (funct3[2] && (op_b == '0)) begin
      special     = 1'b1;
      special_res = funct3[1] ? op_a : '1;
    end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (op_a == INT_MIN) && (op_b == '1)) begin
      special     = 1'b1;
      special_res = funct3[1] ? '0 : INT_MIN;
    end
`else
    special = funct3[2];
`endif
  end

  // acc holds {partial product hi, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : {XLEN{1'b0}})};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] div_rem_next, div_quo_next;

  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .rem      (acc_q[2*XLEN-1:XLEN]),
    .quo      (acc_q[XLEN-1:0]),
    .divisor  (mcand_q),
    .rem_next (div_rem_next),
    .quo_next (div_quo_next)
  );

  always_comb begin
    acc_next = f3_q[2] ? {div_rem_next, div_quo_next} : mul_next;
    prod_fix = cneg_wide(acc_next, neg_a_q ^ neg_b_q);
    if (!f3_q[2])
      calc_res = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (f3_q[1])
      calc_res = cneg(acc_next[2*XLEN-1:XLEN], neg_a_q);
    else
      calc_res = cneg(acc_next[XLEN-1:0], neg_a_q ^ neg_b_q);
  end
`else
  always_comb begin
    acc_next = mul_next;
    prod_fix = cneg_wide(acc_next, neg_a_q ^ neg_b_q);
    calc_res = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end
`endif

  // FSM: IDLE accepts, CALC iterates ITER_CNT times, DONE presents the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            f3_q    <= funct3;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            mcand_q <= abs_b;
            acc_q   <= {{XLEN{1'b0}}, abs_a};
            cnt_q   <= '0;
            if (special) begin
              result_q <= special_res;
              state_q  <= ST_DONE;
            end else begin
              state_q  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER_CNT - 1)) begin
            result_q <= calc_res;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state_q == ST_CALC);
  assign done   = (state_q == ST_DONE);
  assign stall  = start & ~done;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random RV32M ops against
// an arithmetic reference model; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done, stall;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sbu, q;
    logic [63:0] ua, ub, p;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    sbu = $signed({32'b0, b});
    ua  = {32'b0, a};
    ub  = {32'b0, b};
`ifndef MULDIV_DIV_EN
    if (f[2]) return 32'h0;
`endif
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin q = sa * sb; p = q; return p[63:32]; end
      3'd2: begin q = sa * sbu; p = q; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
`else
    if (f[2]) return 1;
    return 33;
`endif
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Steps skip+lat cycles from the current point, checking handshake each cycle
  task automatic run_cycles(input logic [31:0] exp, input int lat, input int skip,
                            input string name, input bit toggle);
    bit exp_busy, exp_done, exp_stall;
    for (int n = 1; n <= skip + lat; n++) begin
      @(posedge clk); #1;
      if (n == skip + 1) begin op_a = $urandom; op_b = $urandom; end
      exp_busy  = (n > skip) && (n < skip + lat);
      exp_done  = (n == skip + lat);
      exp_stall = start & ~exp_done;
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL %s busy cyc %0d: got %b want %b", name, n, busy, exp_busy);
      end
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("FAIL %s done cyc %0d: got %b want %b", name, n, done, exp_done);
      end
      vectors++;
      if (stall !== exp_stall) begin
        miscompares++;
        $display("FAIL %s stall cyc %0d: got %b want %b", name, n, stall, exp_stall);
      end
      if (exp_done) begin
        vectors++;
        if (result !== exp) begin
          miscompares++;
          $display("FAIL %s result: got %h want %h", name, result, exp);
        end
      end
      if (toggle && exp_busy) begin
        start  = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input string name, input bit toggle);
    logic [31:0] exp;
    exp = ref_result(f, a, b);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL %s stall at start: got %b want 1", name, stall);
    end
    run_cycles(exp, ref_lat(f, a, b), 0, name, toggle);
    start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (result !== exp || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s hold: got %h/%b want %h/0", name, result, done, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'd6;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: got busy %b done %b result %h want 0 0 0", busy, done, result);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset idle: got busy %b stall %b want 0 0", busy, stall);
    end
  endtask

  task automatic test_mul();
    do_op(3'd0, 32'd7, 32'd6, "mul_7x6", 1'b0);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulh_m1", 1'b0);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_max", 1'b0);
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, "mulhsu", 1'b0);
    do_op(3'd1, 32'h80000000, 32'h80000000, "mulh_min", 1'b0);
  endtask

  task automatic test_div();
    do_op(3'd4, 32'hFFFFFFEC, 32'd3, "div_m20_3", 1'b0);
    do_op(3'd6, 32'hFFFFFFEC, 32'd3, "rem_m20_3", 1'b0);
    do_op(3'd5, 32'd20, 32'd3, "divu_20_3", 1'b0);
    do_op(3'd5, 32'd5, 32'd0, "divu_by0", 1'b0);
    do_op(3'd7, 32'd5, 32'd0, "remu_by0", 1'b0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 1'b0);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem_ovf", 1'b0);
    do_op(3'd4, 32'd20, 32'd3, "div_20_3", 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rand_operand();
      b = rand_operand();
      do_op(f, a, b, "random", 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    funct3 = 3'd0; op_a = a; op_b = b; start = 1'b1;
    run_cycles(ref_result(3'd0, a, b), 33, 0, "b2b_mul", 1'b0);
    a = 32'd100; b = 32'd0;
    funct3 = 3'd5; op_a = a; op_b = b;
    run_cycles(ref_result(3'd5, a, b), ref_lat(3'd5, a, b), 1, "b2b_divu0", 1'b0);
    a = $urandom; b = $urandom_range(1, 1000);
    funct3 = 3'd6; op_a = a; op_b = b;
    run_cycles(ref_result(3'd6, a, b), ref_lat(3'd6, a, b), 1, "b2b_rem", 1'b0);
    a = $urandom; b = $urandom;
    funct3 = 3'd1; op_a = a; op_b = b;
    run_cycles(ref_result(3'd1, a, b), 33, 1, "b2b_mulh", 1'b0);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    do_op(3'd0, 32'd1234, 32'd5678, "pre_reset", 1'b0);
    funct3 = 3'd0; op_a = $urandom; op_b = $urandom; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midcalc busy: got %b want 1", busy);
    end
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL midcalc reset: got busy %b done %b result %h want 0 0 0", busy, done, result);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    do_op(3'd0, 32'd3, 32'd4, "post_reset_mul", 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
